sw_rxbuf_pac: RTL and testbench

Software RX buffer, the receive-side counterpart of the SW TX buffer. It accepts FrameLink frames from hardware and stores the data words in a circular data memory, with one length record per frame in a header FIFO. Software drains frames through a 32-bit MI32 register interface. It sits between the FrameLink output of a processing pipeline and the MI32 bus, so host software can read packets one word at a time.

---
 rtl/sw_rxbuf_pac.sv | 188 ++++++++++++++++++
 tb/tb_sw_rxbuf_pac.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_rxbuf_pac.sv
// sw_rxbuf_pac: FrameLink receive buffer drained by software over MI32.
// Words sit in a circular memory; each frame leaves one byte-length record.
module sw_rxbuf_pac #(
    parameter int DATA_WIDTH = 32,
    parameter int ITEMS      = 512,
    parameter int MAX_FRAMES = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [1:0]            RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    input  logic [31:0]           MI_ADDR,
    input  logic [31:0]           MI_DWR,
    input  logic [3:0]            MI_BE,
    input  logic                  MI_RD,
    input  logic                  MI_WR,
    output logic                  MI_ARDY,
    output logic [31:0]           MI_DRD,
    output logic                  MI_DRDY
);

    localparam int AW = $clog2(ITEMS);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(MAX_FRAMES);
    localparam int CW = FW + 1;
    localparam int LW = PW + 2;

    logic [DATA_WIDTH-1:0] mem [ITEMS];
    logic [LW-1:0]         hdr_mem [MAX_FRAMES];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_base;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] word_cnt;
    logic [FW-1:0] hdr_wr;
    logic [FW-1:0] hdr_rd;
    logic [CW-1:0] frame_cnt;
    logic          err;

    logic [PW-1:0] used_words;
    logic [PW-1:0] free_words;
    logic [PW-1:0] rd_off;
    logic [PW-1:0] head_words;
    logic [LW-1:0] head_len;
    logic [LW-1:0] len_round;
    logic [LW-1:0] frame_len;
    logic [31:0]   rd_data;

    logic hdr_full;
    logic fl_eof;
    logic fl_xfer;
    logic hdr_push;
    logic mi_rd_only;
    logic sel_status;
    logic sel_len;
    logic sel_data;
    logic sel_ctrl;
    logic rel_req;
    logic rel_ok;
    logic data_rd;
    logic data_ok;
    logic err_set;
    logic err_clr;
    logic unused_bits;

    // SOF carries no information here: a frame is everything since the last EOF.
    assign unused_bits = ^{MI_BE, MI_ADDR[31:4], MI_ADDR[1:0],
                           MI_DWR[31:2], RX_SOF_N, len_round[1:0]};

    assign used_words = wr_ptr - rd_base;
    assign free_words = PW'(ITEMS) - used_words;
    assign hdr_full   = (frame_cnt == CW'(MAX_FRAMES));
    assign fl_eof     = ~RX_EOF_N;

    assign RX_DST_RDY_N = RESET
                        | (free_words == '0)
                        | (hdr_full & fl_eof);

    assign fl_xfer   = ~RX_SRC_RDY_N & ~RX_DST_RDY_N;
    assign hdr_push  = fl_xfer & fl_eof;
    assign frame_len = {word_cnt, 2'b00} + LW'(RX_REM) + LW'(1);

    assign head_len   = (frame_cnt != '0) ? hdr_mem[hdr_rd] : '0;
    assign len_round  = head_len + LW'(3);
    assign head_words = len_round[LW-1:2];
    assign rd_off     = rd_ptr - rd_base;

    assign sel_status = (MI_ADDR[3:2] == 2'd0);
    assign sel_len    = (MI_ADDR[3:2] == 2'd1);
    assign sel_data   = (MI_ADDR[3:2] == 2'd2);
    assign sel_ctrl   = (MI_ADDR[3:2] == 2'd3);

    // A write wins a collision; the read half then returns zero.
    assign mi_rd_only = MI_RD & ~MI_WR;
    assign MI_ARDY    = MI_RD | MI_WR;

    assign rel_req = MI_WR & sel_ctrl & MI_DWR[0];
    assign rel_ok  = rel_req & (frame_cnt != '0);
    assign data_rd = mi_rd_only & sel_data;
    assign data_ok = data_rd & (rd_off < head_words);
    assign err_set = (rel_req & ~rel_ok) | (data_rd & ~data_ok);
    assign err_clr = MI_WR & sel_ctrl & MI_DWR[1];

    always_comb begin
        rd_data = '0;
        if (mi_rd_only) begin
            unique case (1'b1)
                sel_status: rd_data = {16'(free_words), 16'(frame_cnt)};
                sel_len:    rd_data = 32'(head_len);
                sel_data:   rd_data = data_ok ? mem[rd_ptr[AW-1:0]] : '0;
                sel_ctrl:   rd_data = {30'b0, err, 1'b0};
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (fl_xfer) begin
            mem[wr_ptr[AW-1:0]] <= RX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (hdr_push) begin
            hdr_mem[hdr_wr] <= frame_len;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr    <= '0;
            word_cnt  <= '0;
            hdr_wr    <= '0;
        end else if (fl_xfer) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (fl_eof) begin
                word_cnt <= '0;
                hdr_wr   <= hdr_wr + FW'(1);
            end else begin
                word_cnt <= word_cnt + PW'(1);
            end
        end
    end

    // Release rewinds the read pointer to the next frame, discarding any unread words.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_base <= '0;
            rd_ptr  <= '0;
            hdr_rd  <= '0;
        end else if (rel_ok) begin
            rd_base <= rd_base + head_words;
            rd_ptr  <= rd_base + head_words;
            hdr_rd  <= hdr_rd + FW'(1);
        end else if (data_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt <= '0;
            err       <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt + CW'(hdr_push) - CW'(rel_ok);
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MI_DRDY <= 1'b0;
            MI_DRD  <= '0;
        end else begin
            MI_DRDY <= MI_RD;
            MI_DRD  <= rd_data;
        end
    end

endmodule

// File: tb/tb_sw_rxbuf_pac.sv
// tb_sw_rxbuf_pac: scoreboard bench for the software RX buffer.
// Reads queue expected data; a negedge monitor pops and compares.
module tb_sw_rxbuf_pac;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] RX_DATA;
    logic [1:0]  RX_REM;
    logic        RX_SOF_N;
    logic        RX_EOF_N;
    logic        RX_SRC_RDY_N;
    logic        RX_DST_RDY_N;
    logic [31:0] MI_ADDR;
    logic [31:0] MI_DWR;
    logic [3:0]  MI_BE;
    logic        MI_RD;
    logic        MI_WR;
    logic        MI_ARDY;
    logic [31:0] MI_DRD;
    logic        MI_DRDY;

    always #5 CLK = ~CLK;

    sw_rxbuf_pac dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RX_DATA      (RX_DATA),
        .RX_REM       (RX_REM),
        .RX_SOF_N     (RX_SOF_N),
        .RX_EOF_N     (RX_EOF_N),
        .RX_SRC_RDY_N (RX_SRC_RDY_N),
        .RX_DST_RDY_N (RX_DST_RDY_N),
        .MI_ADDR      (MI_ADDR),
        .MI_DWR       (MI_DWR),
        .MI_BE        (MI_BE),
        .MI_RD        (MI_RD),
        .MI_WR        (MI_WR),
        .MI_ARDY      (MI_ARDY),
        .MI_DRD       (MI_DRD),
        .MI_DRDY      (MI_DRDY)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic  exp;
        bit    timeout;
        string name;
    } rdy_exp_t;

    rd_exp_t  sbq[$];
    rdy_exp_t rq[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    bit       drain_req = 1'b0;
    bit       drain_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        rd_exp_t  e;
        rdy_exp_t r;
        if (MI_DRDY) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_drdy: got %08h want none", MI_DRD);
            end else begin
                e = sbq.pop_front();
                if (MI_DRD !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s: got %08h at cyc %0d want %08h at cyc %0d",
                             e.name, MI_DRD, cyc, e.data, e.due);
                end
            end
        end
        if (rq.size() > 0) begin
            r = rq.pop_front();
            checks++;
            if (r.timeout) begin
                errors++;
                $display("FAIL %s: handshake never completed", r.name);
            end else if (RX_DST_RDY_N !== r.exp) begin
                errors++;
                $display("FAIL %s: RX_DST_RDY_N got %b want %b",
                         r.name, RX_DST_RDY_N, r.exp);
            end
        end
        if (drain_req && !drain_done) begin
            checks++;
            if (sbq.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d reads got no MI_DRDY, want 0",
                         sbq.size());
            end
            drain_done = 1'b1;
        end
    end

    function automatic logic [31:0] pat(input logic [7:0] tag, input int i);
        return {tag, 8'hC3, 16'(i)};
    endfunction

    task automatic expect_rdy(input logic v, input string name);
        rq.push_back('{exp: v, timeout: 1'b0, name: name});
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic mi_read(input logic [31:0] a, input logic [31:0] exp,
                           input string name);
        MI_ADDR = a;
        MI_RD   = 1'b1;
        sbq.push_back('{data: exp, due: cyc + 1, name: name});
        @(posedge CLK);
        #1;
        MI_RD = 1'b0;
    endtask

    task automatic mi_write(input logic [31:0] a, input logic [31:0] d);
        MI_ADDR = a;
        MI_DWR  = d;
        MI_WR   = 1'b1;
        @(posedge CLK);
        #1;
        MI_WR = 1'b0;
    endtask

    task automatic fl_word(input logic [31:0] d, input logic sof,
                           input logic eof, input logic [1:0] rem);
        int n = 0;
        RX_DATA      = d;
        RX_SOF_N     = ~sof;
        RX_EOF_N     = ~eof;
        RX_REM       = rem;
        RX_SRC_RDY_N = 1'b0;
        @(negedge CLK);
        while (RX_DST_RDY_N && n < 2000) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 2000) begin
            rq.push_back('{exp: 1'b0, timeout: 1'b1, name: "fl_timeout"});
        end
        @(posedge CLK);
        #1;
        RX_SRC_RDY_N = 1'b1;
        RX_SOF_N     = 1'b1;
        RX_EOF_N     = 1'b1;
    endtask

    task automatic send_frame(input int n, input logic [7:0] tag,
                              input logic [1:0] rem);
        for (int i = 0; i < n; i++) begin
            fl_word(pat(tag, i), i == 0, i == n - 1, rem);
        end
    endtask

    task automatic read_frame(input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++) begin
            mi_read(32'h8, pat(tag, i), "data_word");
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET        = 1'b1;
        RX_DATA      = '0;
        RX_REM       = '0;
        RX_SOF_N     = 1'b1;
        RX_EOF_N     = 1'b1;
        RX_SRC_RDY_N = 1'b1;
        MI_ADDR      = '0;
        MI_DWR       = '0;
        MI_BE        = 4'hF;
        MI_RD        = 1'b0;
        MI_WR        = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        expect_rdy(1'b1, "rdy_in_reset");
        RESET = 1'b0;
        expect_rdy(1'b0, "rdy_idle");
        mi_read(32'h0, 32'h0200_0000, "status_idle");
        mi_read(32'h4, 32'h0, "head_len_idle");
        mi_read(32'hC, 32'h0, "control_idle");

        // 3-word frame, stray SOF on word 2
        fl_word(32'h1111_1111, 1'b1, 1'b0, 2'd1);
        fl_word(32'h2222_2222, 1'b1, 1'b0, 2'd1);
        fl_word(32'h3333_3333, 1'b0, 1'b1, 2'd1);
        mi_read(32'h4, 32'd10, "head_len_3w");
        mi_read(32'h0, 32'h01FD_0001, "status_3w");
        mi_read(32'h8, 32'h1111_1111, "data_3w_0");
        mi_read(32'h8, 32'h2222_2222, "data_3w_1");
        mi_read(32'h8, 32'h3333_3333, "data_3w_2");
        mi_read(32'h8, 32'h0, "data_overrun");
        mi_read(32'hC, 32'h2, "err_set");
        MI_ADDR = 32'hC;
        MI_DWR  = 32'h2;
        MI_RD   = 1'b1;
        MI_WR   = 1'b1;
        sbq.push_back('{data: 32'h0, due: cyc + 1, name: "rd_wr_collide"});
        @(posedge CLK);
        #1;
        MI_RD = 1'b0;
        MI_WR = 1'b0;
        mi_read(32'hC, 32'h0, "err_cleared");
        mi_write(32'hC, 32'h1);
        mi_read(32'h0, 32'h0200_0000, "status_released");
        mi_write(32'hC, 32'h1);
        mi_read(32'hC, 32'h2, "err_empty_release");
        mi_write(32'hC, 32'h2);

        // header FIFO full
        for (int i = 0; i < 16; i++) begin
            fl_word(32'hA000_0000 + 32'(i), 1'b1, 1'b1, 2'd3);
        end
        mi_read(32'h0, 32'h01F0_0010, "status_16");
        RX_DATA      = 32'hA000_0010;
        RX_REM       = 2'd3;
        RX_SOF_N     = 1'b0;
        RX_EOF_N     = 1'b0;
        RX_SRC_RDY_N = 1'b0;
        expect_rdy(1'b1, "rdy_hdr_full");
        MI_ADDR = 32'hC;
        MI_DWR  = 32'h1;
        MI_WR   = 1'b1;
        expect_rdy(1'b1, "rdy_during_release");
        MI_WR = 1'b0;
        expect_rdy(1'b0, "rdy_after_release");
        RX_SRC_RDY_N = 1'b1;
        RX_SOF_N     = 1'b1;
        RX_EOF_N     = 1'b1;
        mi_read(32'h0, 32'h01F0_0010, "status_17th");
        mi_read(32'h4, 32'd4, "head_len_1w");
        mi_read(32'h8, 32'hA000_0001, "data_1w");
        for (int i = 0; i < 16; i++) begin
            mi_write(32'hC, 32'h1);
        end
        mi_read(32'h0, 32'h0200_0000, "status_drained");

        // fill to zero free words, then wrap
        send_frame(380, 8'h30, 2'd3);
        mi_write(32'hC, 32'h1);
        send_frame(256, 8'h31, 2'd3);
        send_frame(256, 8'h32, 2'd3);
        expect_rdy(1'b1, "rdy_mem_full");
        mi_read(32'h0, 32'h0000_0002, "status_full");
        mi_write(32'hC, 32'h1);
        mi_read(32'h0, 32'h0100_0001, "status_half");
        send_frame(200, 8'h33, 2'd2);
        mi_write(32'hC, 32'h1);
        mi_read(32'h0, 32'h0138_0001, "status_wrap");
        mi_read(32'h4, 32'd799, "head_len_wrap");
        read_frame(200, 8'h33);
        mi_read(32'h8, 32'h0, "data_wrap_over");
        mi_write(32'hC, 32'h3);
        mi_read(32'h0, 32'h0200_0000, "status_wrap_done");

        // reset mid-frame
        for (int i = 0; i < 5; i++) begin
            fl_word(pat(8'h40, i), i == 0, 1'b0, 2'd3);
        end
        RESET = 1'b1;
        expect_rdy(1'b1, "rdy_reset_mid");
        RESET = 1'b0;
        mi_read(32'h0, 32'h0200_0000, "status_after_reset");
        mi_read(32'h4, 32'h0, "head_len_after_reset");
        send_frame(2, 8'h41, 2'd0);
        mi_read(32'h4, 32'd5, "head_len_post_reset");
        read_frame(2, 8'h41);
        mi_write(32'hC, 32'h1);

        // EOF commit coincides with release
        send_frame(1, 8'h50, 2'd3);
        send_frame(2, 8'h51, 2'd1);
        fl_word(pat(8'h52, 0), 1'b1, 1'b0, 2'd0);
        fl_word(pat(8'h52, 1), 1'b0, 1'b0, 2'd0);
        RX_DATA      = pat(8'h52, 2);
        RX_REM       = 2'd0;
        RX_EOF_N     = 1'b0;
        RX_SRC_RDY_N = 1'b0;
        MI_ADDR      = 32'hC;
        MI_DWR       = 32'h1;
        MI_WR        = 1'b1;
        @(posedge CLK);
        #1;
        RX_SRC_RDY_N = 1'b1;
        RX_EOF_N     = 1'b1;
        MI_WR        = 1'b0;
        mi_read(32'h0, 32'h01FB_0002, "status_commit_release");
        mi_read(32'h4, 32'd6, "head_len_second");
        read_frame(2, 8'h51);
        mi_write(32'hC, 32'h1);
        mi_read(32'h4, 32'd9, "head_len_third");
        read_frame(3, 8'h52);
        mi_write(32'hC, 32'h1);
        mi_read(32'h0, 32'h0200_0000, "status_final");

        repeat (3) @(posedge CLK);
        drain_req = 1'b1;
        for (int i = 0; i < 10 && !drain_done; i++) begin
            @(posedge CLK);
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
